// File: rtl/aoi_pipe.sv
// aoi_pipe: two-stage valid/ready pipeline evaluating a per-bit AOI21/OAI21/AOI22/OAI22
// gate selected per transaction, with a saturating count of completed output handshakes.

// One result bit: mode[0] picks AND-OR-invert vs OR-AND-invert, mode[1] adds the d term.
module aoi_cell (
    input  logic [1:0] mode,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic       y
);
    logic t_ab;
    logic t_cd;

    // first-level term pairs share the same gate type; the second level is its dual
    always_comb begin
        t_ab = mode[0] ? (a | b) : (a & b);
        t_cd = c;
        if (mode[1]) t_cd = mode[0] ? (c | d) : (c & d);
        y = mode[0] ? ~(t_ab & t_cd) : ~(t_ab | t_cd);
    end
endmodule

module aoi_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       y_mode,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ops_cnt
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic [1:0]       mode;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
        logic [WIDTH-1:0] d;
    } req_t;

    typedef struct packed {
        logic [1:0]       mode;
        logic [WIDTH-1:0] y;
    } rsp_t;

    logic [STAGES:1]  vld_pipe;
    req_t             s1_q;
    rsp_t             s2_q;
    req_t             req;
    logic [WIDTH-1:0] y_comb;
    logic             s1_adv;
    logic             s2_adv;
    logic             out_hs;

    // a stage may load when it is empty or the stage after it is draining
    always_comb begin
        req      = '{mode: mode, a: a, b: b, c: c, d: d};
        s2_adv   = ~vld_pipe[2] | out_ready;
        s1_adv   = ~vld_pipe[1] | s2_adv;
        in_ready = s1_adv;
        out_hs   = vld_pipe[2] & out_ready;
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            aoi_cell u_cell (
                .mode (s1_q.mode),
                .a    (s1_q.a[i]),
                .b    (s1_q.b[i]),
                .c    (s1_q.c[i]),
                .d    (s1_q.d[i]),
                .y    (y_comb[i])
            );
        end
    endgenerate

    // pipeline registers; data only loads with a valid beat so y stays quiet over bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) s1_q <= req;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) s2_q <= '{mode: s1_q.mode, y: y_comb};
            end
        end
    end

    // completed-handshake counter: clear beats a concurrent handshake, no wrap at the top
    always_ff @(posedge clk) begin
        if (rst || cnt_clr)
            ops_cnt <= '0;
        else if (out_hs && (ops_cnt != {CNT_W{1'b1}}))
            ops_cnt <= ops_cnt + CNT_W'(1);
    end

    always_comb begin
        out_valid = vld_pipe[2];
        y         = s2_q.y;
        y_mode    = s2_q.mode;
    end
endmodule

// File: tb/tb_aoi_pipe.sv
// Directed + randomized bench for aoi_pipe (WIDTH=8, CNT_W=3 so saturation is reachable).
module tb_aoi_pipe;
    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    mode;
    logic [W-1:0]  a, b, c, d;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  y;
    logic [1:0]    y_mode;
    logic          cnt_clr;
    logic [CW-1:0] ops_cnt;

    int tests = 0;
    int fails = 0;

    aoi_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_mode    (y_mode),
        .cnt_clr   (cnt_clr),
        .ops_cnt   (ops_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m,
                         input logic [7:0] aa, input logic [7:0] bb,
                         input logic [7:0] cc, input logic [7:0] dd);
        in_valid = v; mode = m; a = aa; b = bb; c = cc; d = dd;
    endtask

    // reference gate, written straight from the truth formulas
    function automatic logic [7:0] fref(input logic [1:0] m, input logic [7:0] aa,
                                        input logic [7:0] bb, input logic [7:0] cc,
                                        input logic [7:0] dd);
        case (m)
            2'd0:    return ~((aa & bb) | cc);
            2'd1:    return ~((aa | bb) & cc);
            2'd2:    return ~((aa & bb) | (cc & dd));
            default: return ~((aa | bb) & (cc | dd));
        endcase
    endfunction

    initial begin
        logic [7:0] exp2 [4];
        logic [9:0] q [$];
        logic [9:0] prev_out;
        logic       prev_stall;
        int         mc;
        logic       hs;

        rst = 1'b1; cnt_clr = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_y",         y,       32'h0);
        chk("rst_y_mode",    y_mode,  32'h0);
        chk("rst_ops_cnt",   ops_cnt, 32'h0);
        rst = 1'b0;

        // T1: ~((F0&CC)|0A) = ~CA = 35, visible on the second edge after presenting it
        out_ready = 1'b1;
        drive(1'b1, 2'd0, 8'hF0, 8'hCC, 8'h0A, 8'h00);
        tick();
        in_valid = 1'b0;
        chk("t1_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_y", y, 32'h35);
        chk("t1_y_mode", y_mode, 32'h0);
        tick();
        chk("t1_drained", {31'd0, out_valid}, 32'd0);
        chk("t1_cnt", ops_cnt, 32'd1);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("clr_cnt", ops_cnt, 32'd0);

        // T2: a=F0 b=CC c=AA d=0F: C0|AA=EA->15, FC&AA=A8->57, C0|0A=CA->35, FC&AF=AC->53
        exp2[0] = 8'h15; exp2[1] = 8'h57; exp2[2] = 8'h35; exp2[3] = 8'h53;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drive(1'b1, k[1:0], 8'hF0, 8'hCC, 8'hAA, 8'h0F);
            else in_valid = 1'b0;
            tick();
            if (k >= 1 && k <= 4) begin
                chk($sformatf("t2_valid%0d", k - 1), {31'd0, out_valid}, 32'd1);
                chk($sformatf("t2_y%0d", k - 1), y, exp2[k-1]);
                chk($sformatf("t2_mode%0d", k - 1), y_mode, k - 1);
            end
        end
        chk("t2_drained", {31'd0, out_valid}, 32'd0);
        chk("t2_cnt", ops_cnt, 32'd4);

        // T3: stall 5 cycles; y = ~a with b=FF c=0 in mode 00
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 8'h10, 8'hFF, 8'h00, 8'h00);
        #1 chk("t3_rdy0", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b1, 2'd0, 8'h11, 8'hFF, 8'h00, 8'h00);
        chk("t3_rdy1", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b1, 2'd0, 8'h12, 8'hFF, 8'h00, 8'h00);
        chk("t3_full_rdy", {31'd0, in_ready}, 32'd0);
        chk("t3_full_vld", {31'd0, out_valid}, 32'd1);
        chk("t3_full_y", y, 32'hEF);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("t3_stall_rdy%0d", s), {31'd0, in_ready}, 32'd0);
            chk($sformatf("t3_stall_y%0d", s), y, 32'hEF);
        end
        out_ready = 1'b1;
        #1 chk("t3_release_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        drive(1'b1, 2'd0, 8'h13, 8'hFF, 8'h00, 8'h00);
        chk("t3_y1", y, 32'hEE);
        tick();
        in_valid = 1'b0;
        chk("t3_y2", y, 32'hED);
        tick();
        chk("t3_y3", y, 32'hEC);
        chk("t3_y3_vld", {31'd0, out_valid}, 32'd1);
        tick();
        chk("t3_empty", {31'd0, out_valid}, 32'd0);

        // T4: 9 handshakes into a 3-bit counter saturate at 7; clear wins over a handshake
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("t4_clr", ops_cnt, 32'd0);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 2'd1, i[7:0], 8'h00, 8'hFF, 8'h00);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();
        chk("t4_sat", ops_cnt, 32'd7);
        chk("t4_drained", {31'd0, out_valid}, 32'd0);
        tick();
        chk("t4_hold", ops_cnt, 32'd7);
        drive(1'b1, 2'd2, 8'hFF, 8'hFF, 8'h00, 8'h00);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t4_pend_vld", {31'd0, out_valid}, 32'd1);
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        chk("t4_clr_wins", ops_cnt, 32'd0);
        chk("t4_consumed", {31'd0, out_valid}, 32'd0);

        // T5: one handshake, then fill both stages and reset
        drive(1'b1, 2'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(); in_valid = 1'b0; tick(); tick();
        chk("t5_pre_cnt", ops_cnt, 32'd1);
        out_ready = 1'b0;
        drive(1'b1, 2'd3, 8'h00, 8'h00, 8'h00, 8'h00);
        tick(); tick();
        in_valid = 1'b0;
        chk("t5_full_vld", {31'd0, out_valid}, 32'd1);
        chk("t5_full_rdy", {31'd0, in_ready}, 32'd0);
        chk("t5_full_y", y, 32'hFF);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_vld", {31'd0, out_valid}, 32'd0);
        chk("t5_rdy", {31'd0, in_ready}, 32'd1);
        chk("t5_y", y, 32'h0);
        chk("t5_y_mode", y_mode, 32'h0);
        chk("t5_cnt", ops_cnt, 32'd0);
        out_ready = 1'b1;
        tick(); tick();
        chk("t5_no_stale", {31'd0, out_valid}, 32'd0);

        // T6: random traffic against a queue model and a counter model
        mc = 0; prev_stall = 1'b0; prev_out = '0;
        for (int cyc = 0; cyc < 10010; cyc++) begin
            if (cyc < 10000) begin
                drive(($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom), 8'($urandom));
                out_ready = ($urandom_range(0, 3) != 0);
                cnt_clr   = ($urandom_range(0, 499) == 0);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
            end
            #1;
            if (prev_stall) begin
                chk("t6_stall_vld", {31'd0, out_valid}, 32'd1);
                chk("t6_stall_data", {y_mode, y}, prev_out);
            end
            chk("t6_cnt", ops_cnt, mc);
            if (in_valid && in_ready) q.push_back({mode, fref(mode, a, b, c, d)});
            hs = out_valid && out_ready;
            if (hs) begin
                if (q.size() == 0) chk("t6_pop_empty", q.size(), 32'd1);
                else chk("t6_data", {y_mode, y}, q.pop_front());
            end
            if (cnt_clr) mc = 0;
            else if (hs && mc < 7) mc++;
            prev_stall = out_valid && !out_ready;
            prev_out   = {y_mode, y};
            tick();
        end
        chk("t6_drained", q.size(), 32'd0);
        chk("t6_end_vld", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
